axi4_lite_read_arbiter: RTL and testbench

//  Two-master AXI4-lite read-channel arbiter: instruction fetch (M0) and execute/LSU (M1) share one AR/R slave port.

---
 rtl/axi_rd_arb_pkg.sv | 19 +
 rtl/axi_rr_pick2.sv | 18 +
 rtl/axi4_lite_read_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axi4_lite_read_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI4-lite read arbiter.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_idx_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last.
import axi_rd_arb_pkg::*;

module axi_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == MST_M1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Two-master AXI4-lite read arbiter (M0 ifetch, M1 execute) onto one AR/R port,
// one outstanding read. Optional R-phase watchdog: define AXI_RD_ARB_TIMEOUT_EN.
import axi_rd_arb_pkg::*;

module axi4_lite_read_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp
);

  arb_state_t        state, state_nxt;
  mst_idx_t          last_grant, gnt;
  logic [1:0]        pick;
  logic              ar_take;
  logic              xfer_done;
  logic              gnt_rready;
  logic              rv;
  logic [DATA_W-1:0] rd;
  logic [1:0]        rr;
  logic              wd_hit;

  axi_rr_pick2 u_pick (
    .req        ({m1_arvalid, m0_arvalid}),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign gnt_rready = (gnt == MST_M1) ? m1_rready : m0_rready;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_cnt;

  // Counts DATA cycles; held at zero in every other state so each entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != ST_DATA) begin
      wd_cnt <= '0;
    end else if (!wd_hit) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_hit = (state == ST_DATA) && (wd_cnt == WD_LIM);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= MST_M1;
      gnt        <= MST_M0;
      s_arvalid  <= 1'b0;
      s_araddr   <= '0;
    end else begin
      state <= state_nxt;
      if (ar_take) begin
        gnt       <= mst_idx_t'(pick[1]);
        s_araddr  <= pick[1] ? m1_araddr : m0_araddr;
        s_arvalid <= 1'b1;
      end else if ((state == ST_ADDR) && s_arready) begin
        s_arvalid <= 1'b0;
      end
      if (xfer_done) begin
        last_grant <= gnt;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    ar_take    = 1'b0;
    xfer_done  = 1'b0;
    rv         = 1'b0;
    rd         = '0;
    rr         = RESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (|pick) begin
          // arready is combinational; keep it quiet while reset is asserted
          m0_arready = pick[0] & ~rst;
          m1_arready = pick[1] & ~rst;
          ar_take    = 1'b1;
          state_nxt  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (s_arready) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wd_hit) begin
          // Slave is late: answer the master ourselves and hold the slave port shut.
          rv = 1'b1;
          rr = RESP_SLVERR;
          if (gnt_rready) begin
            xfer_done = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end else begin
          s_rready = gnt_rready;
          rv       = s_rvalid;
          rd       = s_rdata;
          rr       = s_rresp;
          if (s_rvalid && gnt_rready) begin
            xfer_done = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
`ifdef AXI_RD_ARB_TIMEOUT_EN
        s_rready = 1'b1;
        if (s_rvalid) begin
          state_nxt = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
    endcase
  end

  assign m0_rvalid = rv & (gnt == MST_M0);
  assign m0_rdata  = (gnt == MST_M0) ? rd : '0;
  assign m0_rresp  = (gnt == MST_M0) ? rr : RESP_OKAY;
  assign m1_rvalid = rv & (gnt == MST_M1);
  assign m1_rdata  = (gnt == MST_M1) ? rd : '0;
  assign m1_rresp  = (gnt == MST_M1) ? rr : RESP_OKAY;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Scoreboard bench for axi4_lite_read_arbiter: master/slave stimulus processes,
// a bus-level reference model and a monitor that pops expected reads.
module tb_axi4_lite_read_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_arvalid, m_rready;
  logic [63:0] m_araddr [2];
  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;

  logic [1:0]  m_arready_w, m_rvalid_w;
  logic [63:0] m_rdata_w [2];
  logic [1:0]  m_rresp_w [2];
  assign m_arready_w  = {m1_arready, m0_arready};
  assign m_rvalid_w   = {m1_rvalid, m0_rvalid};
  assign m_rdata_w[0] = m0_rdata;
  assign m_rdata_w[1] = m1_rdata;
  assign m_rresp_w[0] = m0_rresp;
  assign m_rresp_w[1] = m1_rresp;

  always #5 clk = ~clk;

  axi4_lite_read_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m0_arready), .m0_araddr(m_araddr[0]),
    .m0_rvalid(m0_rvalid), .m0_rready(m_rready[0]), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m1_arready), .m1_araddr(m_araddr[1]),
    .m1_rvalid(m1_rvalid), .m1_rready(m_rready[1]), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave memory content: data and response are a fixed function of the address.
  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, a[63:32]};
  endfunction
  function automatic logic [1:0] mem_resp(input logic [63:0] a);
    return a[4:3];
  endfunction
  function automatic int pick_dly(input int fix, input int mx);
    return (fix >= 0) ? fix : int'($urandom_range(0, mx));
  endfunction

  // Control knobs written only by the main sequence
  int req_total [2];
  int ar_fix, r_fix;
  bit mute, rr_pat, exp_to;

  // ---------------- masters ----------------
  int req_done [2];
  initial begin
    int  lo_run [2];
    logic [1:0] hs;
    m_arvalid = '0; m_rready = '0; m_araddr[0] = '0; m_araddr[1] = '0;
    req_done[0] = 0; req_done[1] = 0; lo_run[0] = 0; lo_run[1] = 0;
    forever begin
      @(negedge clk);
      hs = m_arvalid & m_arready_w;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (lo_run[i] >= (rr_pat ? 3 : 2)) m_rready[i] = 1'b1;
        else m_rready[i] = rr_pat ? 1'b0 : ($urandom_range(0, 3) != 0);
        lo_run[i] = m_rready[i] ? 0 : lo_run[i] + 1;
        if (rst) begin
          m_arvalid[i] = 1'b0;
        end else begin
          if (hs[i]) begin
            m_arvalid[i] = 1'b0;
            req_done[i]++;
          end
          if (!m_arvalid[i]) begin
            if (req_done[i] < req_total[i]) begin
              m_arvalid[i] = 1'b1;
              m_araddr[i]  = (i == 0 && req_done[0] == 0) ? 64'h0000_0000_8000_0000
                                                          : {$urandom, $urandom};
            end else begin
              m_araddr[i] = {$urandom, $urandom};
            end
          end
        end
      end
    end
  end

  // ---------------- slave ----------------
  initial begin
    bit ar_hs, r_hs, armed;
    int ar_dly, r_dly;
    int ph;
    logic [63:0] sl_addr, hs_addr;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    armed = 0; ar_dly = 0; r_dly = 0; ph = 0; sl_addr = '0;
    forever begin
      @(negedge clk);
      ar_hs = s_arvalid & s_arready;
      r_hs  = s_rvalid & s_rready;
      hs_addr = s_araddr;
      @(posedge clk); #1;
      if (rst) begin
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        ph = 0; armed = 0;
      end else begin
        if (ar_hs) begin
          s_arready = 1'b0; sl_addr = hs_addr; armed = 0;
          r_dly = pick_dly(r_fix, 3); ph = 1;
        end
        if (r_hs) begin
          s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; ph = 0;
        end
        if (ph == 0) begin
          if (s_arvalid && !s_arready) begin
            if (!armed) begin
              ar_dly = pick_dly(ar_fix, 4);
              armed  = 1;
            end
            if (ar_dly == 0) s_arready = 1'b1;
            else ar_dly--;
          end
        end else if (!s_rvalid && !mute) begin
          if (r_dly == 0) begin
            s_rvalid = 1'b1; s_rdata = mem_data(sl_addr); s_rresp = mem_resp(sl_addr);
          end else begin
            r_dly--;
          end
        end
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef struct packed {
    logic        m;
    logic [63:0] addr;
    logic        to;
  } txn_t;

  txn_t exp_q [$];
  bit   free = 1, last = 1, ar_done = 0, drain = 0;
  int   cyc = 0, ar_cyc = 0, resp_cnt = 0;

  initial begin
    txn_t t;
    bit   w, free_nx;
    forever begin
      @(negedge clk);
      cyc++;
      free_nx = 0;
      if (rst) begin
        exp_q.delete();
        free = 1; last = 1; ar_done = 0; drain = 0;
      end else if (free) begin
        chk("idle_s_arvalid", s_arvalid, 0);
        chk("idle_s_rready", s_rready, 0);
        chk("idle_rvalid", m_rvalid_w, 0);
        if (|m_arvalid) begin
          w = (&m_arvalid) ? !last : m_arvalid[1];
          chk("arready_m0", m_arready_w[0], w == 0);
          chk("arready_m1", m_arready_w[1], w == 1);
          t.m = w; t.addr = m_araddr[w]; t.to = exp_to;
          exp_q.push_back(t);
          free = 0; ar_done = 0;
        end else begin
          chk("arready_none", m_arready_w, 0);
        end
      end else begin
        t = exp_q[0];
        chk("busy_arready", m_arready_w, 0);
        if (!ar_done) begin
          chk("s_arvalid", s_arvalid, 1);
          chk("s_araddr", s_araddr, t.addr);
          chk("addr_s_rready", s_rready, 0);
          chk("addr_rvalid", m_rvalid_w, 0);
          if (s_arready) begin
            ar_done = 1; ar_cyc = cyc;
          end
        end else if (!drain) begin
          chk("data_s_arvalid", s_arvalid, 0);
          chk("nongnt_rvalid", m_rvalid_w[!t.m], 0);
          chk("nongnt_rdata", m_rdata_w[!t.m], 0);
          if (t.to) begin
            if (cyc - ar_cyc <= TO) begin
              chk("wd_pre_rvalid", m_rvalid_w[t.m], 0);
              chk("wd_pre_s_rready", s_rready, m_rready[t.m]);
            end else begin
              chk("wd_rvalid", m_rvalid_w[t.m], 1);
              chk("wd_rresp", m_rresp_w[t.m], 2'b10);
              chk("wd_rdata", m_rdata_w[t.m], 0);
              if (m_rready[t.m]) begin
                void'(exp_q.pop_front());
                last = t.m; drain = 1; resp_cnt++;
              end
            end
          end else begin
            chk("gnt_rvalid", m_rvalid_w[t.m], s_rvalid);
            chk("gnt_s_rready", s_rready, m_rready[t.m]);
            if (s_rvalid) begin
              chk("rdata", m_rdata_w[t.m], mem_data(t.addr));
              chk("rresp", m_rresp_w[t.m], mem_resp(t.addr));
            end
            if (s_rvalid && m_rready[t.m]) begin
              void'(exp_q.pop_front());
              last = t.m; free_nx = 1; resp_cnt++;
            end
          end
        end else begin
          chk("drain_rvalid", m_rvalid_w, 0);
          chk("drain_s_rready", s_rready, 1);
          if (s_rvalid) begin
            drain = 0; free_nx = 1;
          end
        end
        if (free_nx) free = 1;
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic wait_resp(input int target, input int budget);
    int k = 0;
    while (resp_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("resp_count", resp_cnt, target);
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_arready", m_arready_w, 0);
    chk("rst_rvalid", m_rvalid_w, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
  endtask

  initial begin
    int n = 0;
    int k;
    rst = 1'b1;
    req_total[0] = 0; req_total[1] = 0;
    ar_fix = -1; r_fix = -1; mute = 0; rr_pat = 0; exp_to = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    @(posedge clk); #2 rst = 1'b0;

    // single M0 read, fastest slave
    ar_fix = 0; r_fix = 0;
    req_total[0]++; n++;
    wait_resp(n, 50);

    // both masters contend for three rounds each
    ar_fix = -1; r_fix = -1;
    req_total[0] += 3; req_total[1] += 3; n += 6;
    wait_resp(n, 200);

    // slave holds arready off for 4 cycles
    ar_fix = 4;
    req_total[1]++; n++;
    wait_resp(n, 50);
    ar_fix = -1;

    // slave data waits on a master that keeps rready low
    r_fix = 0; rr_pat = 1;
    req_total[0]++; req_total[1]++; n += 2;
    wait_resp(n, 100);
    r_fix = -1; rr_pat = 0;

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 2);
      if (k != 1) begin req_total[0]++; n++; end
      if (k != 0) begin req_total[1]++; n++; end
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_resp(n, 6000);

    // reset while a read is in its data phase
    mute = 1;
    req_total[0]++;
    k = 0;
    while (!(ar_done && !free) && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("reach_data_phase", k < 50, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_vals();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    mute = 0;
    req_total[0]++; req_total[1]++; n += 2;
    wait_resp(n, 100);

`ifdef AXI_RD_ARB_TIMEOUT_EN
    // slave never answers until released; watchdog must respond first
    exp_to = 1; mute = 1;
    req_total[0]++; n++;
    wait_resp(n, 100);
    exp_to = 0;
    repeat (3) @(posedge clk);
    mute = 0;
    req_total[1]++; n++;
    wait_resp(n, 100);
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 90000);
    $fatal(1, "bench timeout");
  end

endmodule
